// File: rtl/data_mem_arbiter.sv
// Shares the single data-memory port between the CPU load/store path and an external requester.
// Ownership is registered round-robin with a bounded hold; the CPU is stalled while it waits.
module data_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int HOLD_MAX      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cpu_req_i,
  input  logic                     cpu_we_i,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata_i,
  output logic                     cpu_gnt_o,
  output logic [DATA_WIDTH-1:0]    cpu_rdata_o,
  output logic                     cpu_stall_o,
  input  logic                     ext_req_i,
  input  logic                     ext_we_i,
  input  logic [ADDRESS_WIDTH-1:0] ext_addr_i,
  input  logic [DATA_WIDTH-1:0]    ext_wdata_i,
  output logic                     ext_gnt_o,
  output logic [DATA_WIDTH-1:0]    ext_rdata_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
  output logic [15:0]              contention_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CPU = 2'd1, EXT = 2'd2} owner_t;

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);

  owner_t           owner;
  owner_t           owner_next;
  owner_t           last_owner;
  logic [CNT_W-1:0] beat_cnt;
  logic             owner_req;
  logic             hold_done;

  // The beat completing this cycle is the one that would reach HOLD_MAX.
  assign hold_done = (beat_cnt >= HOLD_LAST);
  assign owner_req = ((owner == CPU) && cpu_req_i) || ((owner == EXT) && ext_req_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner      <= IDLE;
      last_owner <= EXT;
      beat_cnt   <= '0;
    end else begin
      owner <= owner_next;
      if (owner_next != IDLE) begin
        last_owner <= owner_next;
      end
      if (owner_next != owner) begin
        beat_cnt <= '0;
      end else if (owner_req && (beat_cnt != HOLD_SAT)) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    owner_next = owner;
    case (owner)
      IDLE: begin
        if (cpu_req_i && ext_req_i) begin
          if (last_owner == CPU) owner_next = EXT;
          else                   owner_next = CPU;
        end else if (cpu_req_i) begin
          owner_next = CPU;
        end else if (ext_req_i) begin
          owner_next = EXT;
        end else begin
          owner_next = IDLE;
        end
      end
      CPU: begin
        if (!cpu_req_i) begin
          if (ext_req_i) owner_next = EXT;
          else           owner_next = IDLE;
        end else if (ext_req_i && hold_done) begin
          owner_next = EXT;
        end
      end
      EXT: begin
        if (!ext_req_i) begin
          if (cpu_req_i) owner_next = CPU;
          else           owner_next = IDLE;
        end else if (cpu_req_i && hold_done) begin
          owner_next = CPU;
        end
      end
      default: owner_next = IDLE;
    endcase
  end

  always_comb begin
    cpu_gnt_o   = 1'b0;
    ext_gnt_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (owner)
      CPU: begin
        cpu_gnt_o   = 1'b1;
        mem_we_o    = cpu_req_i && cpu_we_i;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
      end
      EXT: begin
        ext_gnt_o   = 1'b1;
        mem_we_o    = ext_req_i && ext_we_i;
        mem_addr_o  = ext_addr_i;
        mem_wdata_o = ext_wdata_i;
      end
      default: ;
    endcase
  end

  assign cpu_rdata_o = mem_rdata_i;
  assign ext_rdata_o = mem_rdata_i;
  assign cpu_stall_o = cpu_req_i && !cpu_gnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      contention_o <= '0;
    end else if (cpu_stall_o && (contention_o != 16'hFFFF)) begin
      contention_o <= contention_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus pushes expected beats, a negedge monitor pops them.
// A second instance with a very long hold time exercises contention-counter saturation.
module tb_data_mem_arbiter;

  typedef struct {
    bit          is_ext;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_gnt, cpu_stall, ext_gnt, mem_we;
  logic [31:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] contention;

  logic        sat_rst_n;
  logic        sat_cpu_req, sat_cpu_we, sat_ext_req, sat_ext_we;
  logic [31:0] sat_cpu_addr, sat_cpu_wdata, sat_ext_addr, sat_ext_wdata;
  logic        sat_cpu_gnt, sat_cpu_stall, sat_ext_gnt, sat_mem_we;
  logic [31:0] sat_cpu_rdata, sat_ext_rdata, sat_mem_addr, sat_mem_wdata, sat_mem_rdata;
  logic [15:0] sat_contention;
  bit          sat_done = 1'b0;

  beat_t exp_q[$];
  beat_t exp_beat;
  int    checks = 0;
  int    errors = 0;

  // Memory model: one fixed word at 0x20, otherwise the inverted address.
  assign mem_rdata     = (mem_addr == 32'h20) ? 32'h12345678 : ~mem_addr;
  assign sat_mem_rdata = ~sat_mem_addr;

  data_mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .HOLD_MAX(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr), .ext_wdata_i(ext_wdata),
    .ext_gnt_o(ext_gnt), .ext_rdata_o(ext_rdata),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .contention_o(contention)
  );

  data_mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .HOLD_MAX(100000)) sat_dut (
    .clk_i(clk), .rst_ni(sat_rst_n),
    .cpu_req_i(sat_cpu_req), .cpu_we_i(sat_cpu_we), .cpu_addr_i(sat_cpu_addr), .cpu_wdata_i(sat_cpu_wdata),
    .cpu_gnt_o(sat_cpu_gnt), .cpu_rdata_o(sat_cpu_rdata), .cpu_stall_o(sat_cpu_stall),
    .ext_req_i(sat_ext_req), .ext_we_i(sat_ext_we), .ext_addr_i(sat_ext_addr), .ext_wdata_i(sat_ext_wdata),
    .ext_gnt_o(sat_ext_gnt), .ext_rdata_o(sat_ext_rdata),
    .mem_we_o(sat_mem_we), .mem_addr_o(sat_mem_addr), .mem_wdata_o(sat_mem_wdata), .mem_rdata_i(sat_mem_rdata),
    .contention_o(sat_contention)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic push_beat(input bit is_ext, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata);
    beat_t b;
    b.is_ext = is_ext;
    b.we     = we;
    b.addr   = addr;
    b.wdata  = wdata;
    b.rdata  = rdata;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at a negedge; returns at the first negedge where the requested grant is visible.
  task automatic wait_gnt(input bit is_ext);
    for (int i = 0; i < 20; i++) begin
      if (is_ext ? ext_gnt : cpu_gnt) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("[TB] FAIL gnt_timeout actual=0 expected=1 (is_ext=%0d)", is_ext);
  endtask

  task automatic apply_stimulus(input bit is_ext, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata);
    push_beat(is_ext, we, addr, wdata, rdata);
    if (is_ext) begin
      ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    @(negedge clk);
    wait_gnt(is_ext);
    tick();
    if (is_ext) ext_req = 1'b0;
    else        cpu_req = 1'b0;
    tick();
  endtask

  // Monitor: every completed beat must match the next expected beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cpu_gnt || ext_gnt) begin
        check_output("gnt_exclusive", 32'(cpu_gnt && ext_gnt), 32'd0);
      end
      if ((cpu_gnt && cpu_req) || (ext_gnt && ext_req)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat actual=1 expected=0 addr=0x%08h", mem_addr);
        end else begin
          exp_beat = exp_q.pop_front();
          check_output("beat_owner_is_ext", 32'(ext_gnt), 32'(exp_beat.is_ext));
          check_output("beat_mem_we", 32'(mem_we), 32'(exp_beat.we));
          check_output("beat_mem_addr", mem_addr, exp_beat.addr);
          check_output("beat_mem_wdata", mem_wdata, exp_beat.wdata);
          check_output("beat_rdata", ext_gnt ? ext_rdata : cpu_rdata, exp_beat.rdata);
        end
      end
    end
  end

  initial begin
    int ext_k, idle_cycles, stall_cycles;
    bit cpu_done, eb, cb;
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check_output("rst_ext_gnt", 32'(ext_gnt), 32'd0);
    check_output("rst_mem_we", 32'(mem_we), 32'd0);
    check_output("rst_mem_addr", mem_addr, 32'd0);
    check_output("rst_mem_wdata", mem_wdata, 32'd0);
    check_output("rst_contention", 32'(contention), 32'd0);
    check_output("rst_stall_follows_req", 32'(cpu_stall), 32'd1);
    cpu_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // CPU write from idle: stall in cycle 0, grant in cycle 1.
    push_beat(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'hFFFFFFEF);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check_output("first_stall", 32'(cpu_stall), 32'd1);
    check_output("first_no_gnt", 32'(cpu_gnt), 32'd0);
    @(negedge clk);
    check_output("first_gnt_latency", 32'(cpu_gnt), 32'd1);
    check_output("first_contention", 32'(contention), 32'd1);
    tick();
    cpu_req = 1'b0;
    tick();

    // Tie from idle after reset goes to the CPU; the next tie goes to EXT.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push_beat(1'b0, 1'b0, 32'h30, 32'h11110030, 32'hFFFFFFCF);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30; cpu_wdata = 32'h11110030;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40; ext_wdata = 32'h22220040;
    tick();
    tick();
    cpu_req = 1'b0; ext_req = 1'b0;
    tick();
    push_beat(1'b1, 1'b0, 32'h60, 32'h22220060, 32'hFFFFFF9F);
    cpu_req = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'h11110050;
    ext_req = 1'b1; ext_addr = 32'h60; ext_wdata = 32'h22220060;
    tick();
    tick();
    cpu_req = 1'b0; ext_req = 1'b0;
    tick();
    @(negedge clk);
    check_output("rr_contention", 32'(contention), 32'd3);

    // EXT streams 10 writes; CPU waits behind 4 of them, gets one beat, EXT resumes.
    for (int k = 0; k < 10; k++) begin
      push_beat(1'b1, 1'b1, 32'h100 + 32'(4 * k), 32'hA0000000 + 32'(k), ~(32'h100 + 32'(4 * k)));
      if (k == 3) push_beat(1'b0, 1'b0, 32'h70, 32'h77, 32'hFFFFFF8F);
    end
    @(posedge clk);
    #1;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h100; ext_wdata = 32'hA0000000;
    ext_k = 0; cpu_done = 1'b0; idle_cycles = 0; stall_cycles = 0;
    for (int cyc = 0; cyc < 60 && !(ext_k == 10 && cpu_done); cyc++) begin
      @(negedge clk);
      eb = ext_gnt && ext_req;
      cb = cpu_gnt && cpu_req;
      if (cyc > 0 && !cpu_gnt && !ext_gnt) idle_cycles++;
      if (cpu_stall) stall_cycles++;
      tick();
      if (cyc == 0) begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h70; cpu_wdata = 32'h77;
      end
      if (cb) begin
        cpu_req = 1'b0;
        cpu_done = 1'b1;
      end
      if (eb) begin
        ext_k++;
        if (ext_k == 10) ext_req = 1'b0;
        else begin
          ext_addr  = 32'h100 + 32'(4 * ext_k);
          ext_wdata = 32'hA0000000 + 32'(ext_k);
        end
      end
    end
    check_output("stream_ext_beats", 32'(ext_k), 32'd10);
    check_output("stream_no_idle_bubble", 32'(idle_cycles), 32'd0);
    check_output("stream_cpu_wait", 32'(stall_cycles), 32'd4);
    tick();
    @(negedge clk);
    check_output("idle_mem_addr", mem_addr, 32'd0);
    check_output("idle_mem_we", 32'(mem_we), 32'd0);
    check_output("idle_mem_wdata", mem_wdata, 32'd0);
    check_output("stream_contention", 32'(contention), 32'd7);
    tick();

    // EXT read of a known word.
    apply_stimulus(1'b1, 1'b0, 32'h20, 32'h55, 32'h12345678);

    // Reset in the middle of a CPU write beat.
    push_beat(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 32'hFFFFFF7F);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'hCAFEF00D;
    @(negedge clk);
    wait_gnt(1'b0);
    check_output("pre_reset_contention", 32'(contention), 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midreset_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check_output("midreset_mem_we", 32'(mem_we), 32'd0);
    check_output("midreset_contention", 32'(contention), 32'd0);
    cpu_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 80000 && !sat_done; i++) @(posedge clk);
    if (!sat_done) begin
      checks++;
      errors++;
      $display("[TB] FAIL sat_timeout actual=0 expected=1");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Saturation: EXT holds the port far longer than the counter range while the CPU waits.
  initial begin
    sat_rst_n = 1'b0;
    sat_cpu_req = 1'b0; sat_cpu_we = 1'b0; sat_cpu_addr = '0; sat_cpu_wdata = '0;
    sat_ext_req = 1'b0; sat_ext_we = 1'b0; sat_ext_addr = '0; sat_ext_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    sat_rst_n = 1'b1;
    sat_ext_req = 1'b1; sat_ext_we = 1'b1; sat_ext_addr = 32'h200; sat_ext_wdata = 32'h5A5A;
    tick();
    sat_cpu_req = 1'b1; sat_cpu_addr = 32'h300;
    repeat (100) @(posedge clk);
    #1;
    check_output("sat_contention_100", 32'(sat_contention), 32'd100);
    repeat (69900) @(posedge clk);
    @(negedge clk);
    check_output("sat_contention_max", 32'(sat_contention), 32'h0000FFFF);
    check_output("sat_cpu_still_waiting", 32'(sat_cpu_gnt), 32'd0);
    check_output("sat_ext_owner", 32'(sat_ext_gnt), 32'd1);
    sat_done = 1'b1;
  end

endmodule
